// File: rtl/demux16_tdm.sv
// 1-to-16 demultiplexer: steers one W-bit lane into a registered 16-channel bank,
// either by explicit sel or by a TDM round-robin counter. DEMUX16_HOLD_FRAME_EN adds a shadow bank.
module demux16_tdm #(
  parameter int unsigned W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    din,
  input  logic            din_valid,
  input  logic [3:0]      sel,
  input  logic            mode,
  input  logic            frame_start,
  output logic [16*W-1:0] out,
  output logic [15:0]     upd,
  output logic [3:0]      chan,
  output logic            frame_done
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e          state_q, state_d;
  logic            mode_q;
  logic [3:0]      chan_q, chan_d;
  logic [16*W-1:0] out_q, out_d;
  logic [15:0]     upd_q, upd_d;
  logic            restart;
  logic [3:0]      wr_idx;
`ifdef DEMUX16_HOLD_FRAME_EN
  logic [16*W-1:0] shadow_q, shadow_d;
`endif

  // A mode change or frame_start resynchronises the TDM counter; a write in the
  // same cycle lands in ch0.
  assign restart = (mode != mode_q) || frame_start;
  assign wr_idx  = restart ? 4'd0 : chan_q;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    out_d   = out_q;
    upd_d   = '0;
`ifdef DEMUX16_HOLD_FRAME_EN
    shadow_d = shadow_q;
`endif
    if (!mode) begin
      state_d = StIdle;
      chan_d  = '0;
      if (din_valid) begin
        out_d[sel*W +: W] = din;
        upd_d             = 16'h0001 << sel;
      end
    end else begin
      if (restart) begin
        state_d = StIdle;
        chan_d  = '0;
      end else if (state_q == StDone) begin
        state_d = StIdle;
      end
      if (din_valid) begin
        chan_d  = wr_idx + 4'd1;
        state_d = (wr_idx == 4'd15) ? StDone : StFill;
`ifdef DEMUX16_HOLD_FRAME_EN
        shadow_d[wr_idx*W +: W] = din;
        // Publish the whole frame on the edge that raises frame_done.
        if (wr_idx == 4'd15) begin
          out_d = shadow_d;
          upd_d = 16'hFFFF;
        end
`else
        out_d[wr_idx*W +: W] = din;
        upd_d                = 16'h0001 << wr_idx;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      chan_q   <= '0;
      out_q    <= '0;
      upd_q    <= '0;
`ifdef DEMUX16_HOLD_FRAME_EN
      shadow_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode;
      chan_q   <= chan_d;
      out_q    <= out_d;
      upd_q    <= upd_d;
`ifdef DEMUX16_HOLD_FRAME_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign out        = out_q;
  assign upd        = upd_q;
  assign chan       = chan_q;
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_demux16_tdm.sv
// Directed self-checking bench for demux16_tdm (W=1); expectations follow
// DEMUX16_HOLD_FRAME_EN when it is defined.
module tb_demux16_tdm;

  localparam int unsigned W = 1;
`ifdef DEMUX16_HOLD_FRAME_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    din;
  logic            din_valid;
  logic [3:0]      sel;
  logic            mode;
  logic            frame_start;
  logic [16*W-1:0] out;
  logic [15:0]     upd;
  logic [3:0]      chan;
  logic            frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  demux16_tdm #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sel         (sel),
    .mode        (mode),
    .frame_start (frame_start),
    .out         (out),
    .upd         (upd),
    .chan        (chan),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic d, input logic [3:0] s, input logic fs);
    din_valid   = v;
    din         = d;
    sel         = s;
    frame_start = fs;
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
  endtask

  // One TDM frame, LSB first, with random idle gaps between writes.
  task automatic tdm_frame(input logic [15:0] pat, input bit gap_first);
    for (int i = 0; i < 16; i++) begin
      if ((i > 0 || gap_first) && $urandom_range(0, 2) == 0) begin
        step(1'b0, 1'b0, 4'd0, 1'b0);
        check("gap_chan_hold", 32'(chan), 32'(i));
      end
      step(1'b1, pat[i], 4'd0, 1'b0);
      if (i == 0) check("frame_first_chan", 32'(chan), 32'd1);
      if (i < 15) check("frame_no_done", 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sel = '0; mode = 1'b0; frame_start = 1'b0;
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_chan", 32'(chan), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    #2 rst_n = 1'b1;

    // Addressed mode
    step(1'b1, 1'b1, 4'd3, 1'b0);
    check("addr3_out", 32'(out), 32'h0008);
    check("addr3_upd", 32'(upd), 32'h0008);
    step(1'b1, 1'b1, 4'd12, 1'b0);
    check("addr12_out", 32'(out), 32'h1008);
    check("addr12_upd", 32'(upd), 32'h1000);
    check("addr_chan", 32'(chan), 32'h0);
    check("addr_fd", 32'(frame_done), 32'h0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    check("addr_idle_upd", 32'(upd), 32'h0);
    check("addr_idle_out", 32'(out), 32'h1008);

    // TDM full frame 16'hA5C3
    mode = 1'b1;
    step(1'b0, 1'b0, 4'd0, 1'b1);
    check("sync_chan", 32'(chan), 32'h0);
    check("sync_out", 32'(out), 32'h1008);
    begin
      logic [15:0] pat;
      pat = 16'hA5C3;
      for (int i = 0; i < 8; i++) step(1'b1, pat[i], 4'd0, 1'b0);
      check("half_out", 32'(out), HOLD ? 32'h1008 : 32'h10C3);
      check("half_chan", 32'(chan), 32'd8);
      for (int i = 8; i < 15; i++) step(1'b1, pat[i], 4'd0, 1'b0);
      check("w15_chan", 32'(chan), 32'd15);
      check("w15_fd", 32'(frame_done), 32'h0);
      step(1'b1, pat[15], 4'd0, 1'b0);
    end
    check("frame_out", 32'(out), 32'hA5C3);
    check("frame_fd", 32'(frame_done), 32'h1);
    check("frame_chan", 32'(chan), 32'h0);
    check("frame_upd", 32'(upd), HOLD ? 32'hFFFF : 32'h8000);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    check("after_fd", 32'(frame_done), 32'h0);
    check("after_upd", 32'(upd), 32'h0);

    // Back-to-back frames, second starting in the DONE cycle
    fd_cnt = 0;
    tdm_frame(16'h3C5A, 1'b1);
    check("f2_out", 32'(out), 32'h3C5A);
    check("f2_fd", 32'(frame_done), 32'h1);
    tdm_frame(16'h0FF0, 1'b0);
    check("f3_out", 32'(out), 32'h0FF0);
    check("f3_fd", 32'(frame_done), 32'h1);
    check("fd_pulses", 32'(fd_cnt), 32'd2);
    step(1'b0, 1'b0, 4'd0, 1'b0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'd0, 1'b0);
    check("pre_rst_out", 32'(out), HOLD ? 32'h0FF0 : 32'h0FFF);
    check("pre_rst_chan", 32'(chan), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'h0);
    check("arst_chan", 32'(chan), 32'h0);
    check("arst_upd", 32'(upd), 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 4'd0, 1'b0);
    check("post_rst_out", 32'(out), HOLD ? 32'h0 : 32'h0001);
    check("post_rst_upd", 32'(upd), HOLD ? 32'h0 : 32'h0001);
    check("post_rst_chan", 32'(chan), 32'd1);

    // Resync with frame_start + din_valid, then mode toggle
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
    check("seven_chan", 32'(chan), 32'd7);
    step(1'b1, 1'b1, 4'd0, 1'b1);
    check("resync_chan", 32'(chan), 32'd1);
    check("resync_fd", 32'(frame_done), 32'h0);
    check("resync_out", 32'(out), HOLD ? 32'h0 : 32'h0001);
    step(1'b1, 1'b1, 4'd0, 1'b0);
    check("resync2_out", 32'(out), HOLD ? 32'h0 : 32'h0003);
    mode = 1'b0;
    step(1'b0, 1'b0, 4'd0, 1'b0);
    check("toggle_chan", 32'(chan), 32'h0);
    check("toggle_fd", 32'(frame_done), 32'h0);
    step(1'b1, 1'b1, 4'd5, 1'b1);
    check("addr_fs_out", 32'(out), HOLD ? 32'h0020 : 32'h0023);
    check("addr_fs_upd", 32'(upd), 32'h0020);
    check("addr_fs_chan", 32'(chan), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux16_tdm.md
Name: demux16_tdm

Overview:
- 1-to-16 demultiplexer. It is the distribution end of the 16:1 channel select path.
- A single input lane is steered into one of 16 registered output channels. The channel is chosen either by an explicit `sel` (addressed mode) or by an internal round-robin counter (TDM mode) that rebuilds a full 16-channel frame from a serial stream.
- Sits downstream of a 16:1 mux / serialiser and recovers the parallel word.

Parameters:
- W, 1, data width of one channel; `din` is W bits, `out` is 16*W bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W  channel data lane.
- din_valid  input  1  qualifies `din`; one channel write per asserted cycle; always accepted, no backpressure.
- sel  input  4  target channel in addressed mode; ignored in TDM mode.
- mode  input  1  0 = addressed, 1 = TDM auto-increment.
- frame_start  input  1  sync pulse; forces the TDM channel counter to 0.
- out  output  16*W  registered channel bank; channel k occupies bits [k*W +: W].
- upd  output  16  registered one-hot strobe naming the channel written in the previous cycle; all zero if no write.
- chan  output  4  current TDM counter value, i.e. the next channel to be written.
- frame_done  output  1  one-cycle pulse after channel 15 is written in TDM mode.

Behaviour:
- Reset (rst_n low, async): `out`=0, `upd`=0, `chan`=0, `frame_done`=0, FSM=IDLE. Reset mid-frame discards the partial frame.
- Latency: a write with `din_valid` at edge N is visible on `out`/`upd` after edge N (1 cycle). Non-written channels hold their value.

Addressed mode (mode=0):
- `din_valid`: out[sel] <= din; upd <= one-hot(sel).
- `chan`, FSM and `frame_done` are unaffected: FSM stays IDLE, `frame_done`=0.

TDM mode (mode=1), FSM states IDLE, FILL, DONE:
- IDLE: `chan`=0. `din_valid` writes ch0, chan <= 1, go FILL.
- FILL: `din_valid` writes ch[chan], chan <= chan+1.
  - On the write to ch15, chan wraps to 0 and the FSM goes to DONE.
  - No `din_valid`: hold state.
- DONE: lasts one cycle with `frame_done`=1.
  - `din_valid` in DONE writes ch0, chan <= 1, go FILL. Back-to-back frames need no gap.
  - Otherwise go IDLE.
- `frame_start` alone: chan <= 0, FSM <= IDLE. Takes precedence over the counter and the DONE exit.
- `frame_start` and `din_valid` in the same cycle: the write goes to ch0, chan <= 1, FSM <= FILL.
- `frame_start` in addressed mode is ignored.

Mode switching:
- `mode` is sampled each cycle.
- A change of `mode` (registered mode_q != mode) clears `chan` to 0 and the FSM to IDLE in that cycle.
- A write in the switching cycle follows the new mode; in TDM the write goes to ch0.

Arithmetic and timing:
- `chan` is a 4-bit counter and wraps modulo 16 with no overflow flag.
- `upd` and `frame_done` are single-cycle strobes, never held.

Optional Feature:
- Macro: DEMUX16_HOLD_FRAME_EN.
- When defined:
  - TDM writes go to an internal shadow bank.
  - `out` is loaded from the shadow bank atomically on the same edge that asserts `frame_done`, so `out` only ever shows complete frames.
  - `upd` in TDM mode pulses 16'hFFFF with `frame_done` instead of per-channel.
  - Addressed mode still writes `out` directly.
  - A partial frame aborted by `frame_start` or a mode change never reaches `out`.
  - Reset clears the shadow bank.
- When undefined: no shadow bank; every TDM write updates `out` immediately, as described under Behaviour.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-frame (after 5 TDM writes) -> `out`=0, `upd`=0, `chan`=0, `frame_done`=0 immediately; next write lands in ch0.
- Addressed, W=1: mode=0, write din=1 with sel=3, then sel=12 -> out=16'h1008, upd=16'h0008 then 16'h1000, `chan` stays 0, no `frame_done`.
- TDM full frame: mode=1, frame_start, then 16 consecutive writes with din = bit pattern of 16'hA5C3 (LSB first) -> out=16'hA5C3; `frame_done` pulses exactly once, 1 cycle after the 16th write; `chan`=0.
- Back-to-back and gaps: two frames with random `din_valid` gaps, the second beginning in the DONE cycle -> both frames correct, two `frame_done` pulses, no channel skipped.
- Resync: after 7 TDM writes, assert frame_start with din_valid=1, din=1 -> ch0 written, `chan`=1, no `frame_done`; mode toggle mid-frame -> `chan`=0.
- With DEMUX16_HOLD_FRAME_EN: during a frame, `out` keeps the previous frame value until `frame_done`, then updates in one edge; an aborted partial frame leaves `out` unchanged.
